// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its sequencer:
// data width, opcode encoding and sequencer FSM states.
package alu_pkg;

   localparam int WIDTH = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_LT  = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU; all results wrap modulo 2**WIDTH.
// LT is an unsigned compare producing 0 or 1.
module alu
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] result_o
);

   // Opcode decode into a single result word
   always_comb begin
      result_o = a_i;
      unique case (op_i)
         OP_ADD: result_o = a_i + b_i;
         OP_SUB: result_o = a_i - b_i;
         OP_AND: result_o = a_i & b_i;
         OP_OR:  result_o = a_i | b_i;
         OP_XOR: result_o = a_i ^ b_i;
         OP_NOT: result_o = ~a_i;
         OP_LT:  result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
         OP_NOP: result_o = a_i;
         default: result_o = a_i;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator sequencer around alu: applies a command's op count+1 times.
// Optional flags outputs (zero/neg/wrap) under ALU_SEQUENCER_FLAGS_EN.
module alu_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
`ifdef ALU_SEQUENCER_FLAGS_EN
   ,
   output logic             rsp_zero,
   output logic             rsp_neg,
   output logic             rsp_wrap
`endif
);

   import alu_pkg::*;

   if (WIDTH != 4) begin : g_width_chk
      $error("alu_sequencer: WIDTH must be 4 to match alu");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] alu_res;

   alu u_alu (
      .a_i      (acc_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (alu_res)
   );

`ifdef ALU_SEQUENCER_FLAGS_EN
   logic             wrap_q, wrap_d;
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;

   // Extra-bit copies of the ALU arithmetic expose carry and borrow
   always_comb begin
      add_w = {1'b0, acc_q} + {1'b0, b_q};
      sub_w = {1'b0, acc_q} - {1'b0, b_q};
   end
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         iter_q  <= '0;
         op_q    <= '0;
         b_q     <= '0;
`ifdef ALU_SEQUENCER_FLAGS_EN
         wrap_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         iter_q  <= iter_d;
         op_q    <= op_d;
         b_q     <= b_d;
`ifdef ALU_SEQUENCER_FLAGS_EN
         wrap_q  <= wrap_d;
`endif
      end
   end

   // Next-state, datapath update and handshake outputs
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      iter_d    = iter_q;
      op_d      = op_q;
      b_d       = b_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
`ifdef ALU_SEQUENCER_FLAGS_EN
      wrap_d    = wrap_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d = cmd_op;
               b_d  = cmd_b;
`ifdef ALU_SEQUENCER_FLAGS_EN
               wrap_d = 1'b0;
`endif
               if (cmd_load) begin
                  acc_d   = cmd_b;
                  state_d = S_DONE;
               end else begin
                  iter_d  = cmd_count;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            acc_d = alu_res;
`ifdef ALU_SEQUENCER_FLAGS_EN
            if ((op_q == OP_ADD) && add_w[WIDTH])
               wrap_d = 1'b1;
            if ((op_q == OP_SUB) && sub_w[WIDTH])
               wrap_d = 1'b1;
`endif
            if (iter_q == '0)
               state_d = S_DONE;
            else
               iter_d = iter_q - 1'b1;
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rsp_data = acc_q;
   assign busy     = (state_q != S_IDLE);

`ifdef ALU_SEQUENCER_FLAGS_EN
   assign rsp_zero = rsp_valid && (acc_q == '0);
   assign rsp_neg  = rsp_valid && acc_q[WIDTH-1];
   assign rsp_wrap = rsp_valid && wrap_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer against an arithmetic model.
// Flag checks are active when ALU_SEQUENCER_FLAGS_EN is defined.
module tb_alu_sequencer;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_load;
   logic [2:0] cmd_op;
   logic [3:0] cmd_b;
   logic [2:0] cmd_count;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       busy;
`ifdef ALU_SEQUENCER_FLAGS_EN
   logic       rsp_zero;
   logic       rsp_neg;
   logic       rsp_wrap;
`endif

   int checks;
   int failures;

   logic [3:0] m_acc;
   bit         m_wrap;

   alu_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_load  (cmd_load),
      .cmd_op    (cmd_op),
      .cmd_b     (cmd_b),
      .cmd_count (cmd_count),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy      (busy)
`ifdef ALU_SEQUENCER_FLAGS_EN
      ,
      .rsp_zero  (rsp_zero),
      .rsp_neg   (rsp_neg),
      .rsp_wrap  (rsp_wrap)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One ALU step computed with plain integer arithmetic
   function automatic logic [3:0] ref_step(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (op)
         3'd0: r = (ia + ib) % 16;
         3'd1: r = (ia - ib + 16) % 16;
         3'd2: r = ia & ib;
         3'd3: r = ia | ib;
         3'd4: r = ia ^ ib;
         3'd5: r = 15 - ia;
         3'd6: r = (ia < ib) ? 1 : 0;
         default: r = ia;
      endcase
      return r[3:0];
   endfunction

   // Apply a whole command to the model; returns expected latency
   task automatic model_cmd(input logic ld, input logic [2:0] op,
                            input logic [3:0] b, input logic [2:0] cnt,
                            output int exp_lat);
      m_wrap = 1'b0;
      if (ld) begin
         m_acc   = b;
         exp_lat = 0;
      end else begin
         for (int i = 0; i <= int'(cnt); i++) begin
            if (op == 3'd0 && (int'(m_acc) + int'(b)) > 15) m_wrap = 1'b1;
            if (op == 3'd1 && int'(m_acc) < int'(b)) m_wrap = 1'b1;
            m_acc = ref_step(op, m_acc, b);
         end
         exp_lat = int'(cnt) + 1;
      end
   endtask

   function automatic logic [2:0] exp_flags();
      return {m_acc == 4'd0, m_acc[3], m_wrap};
   endfunction

   function automatic logic [2:0] dut_flags();
`ifdef ALU_SEQUENCER_FLAGS_EN
      return {rsp_zero, rsp_neg, rsp_wrap};
`else
      return 3'b000;
`endif
   endfunction

   // Present a command and hold it until accepted; junk afterwards
   task automatic issue(input logic ld, input logic [2:0] op,
                        input logic [3:0] b, input logic [2:0] cnt);
      int n;
      @(negedge clk);
      cmd_load  = ld;
      cmd_op    = op;
      cmd_b     = b;
      cmd_count = cnt;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout cmd_ready=%b required=1", cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_load  = 1'($urandom);
      cmd_op    = 3'($urandom);
      cmd_b     = 4'($urandom);
      cmd_count = 3'($urandom);
   endtask

   // Count edges after the accept edge until rsp_valid is seen
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!rsp_valid) begin
         checks++;
         failures++;
         $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
      end
   endtask

   // Full transaction with rsp_ready high; captures response
   task automatic do_cmd(input logic ld, input logic [2:0] op,
                         input logic [3:0] b, input logic [2:0] cnt,
                         output int lat, output logic [3:0] data,
                         output logic [2:0] fl);
      rsp_ready = 1'b1;
      issue(ld, op, b, cnt);
      wait_rsp(lat);
      data = rsp_data;
      fl   = dut_flags();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_load  = 1'b0;
      cmd_op    = 3'd0;
      cmd_b     = 4'd0;
      cmd_count = 3'd0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_acc  = 4'd0;
      m_wrap = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
      end
      checks++;
      if (rsp_data !== 4'd0) begin
         failures++;
         $display("FAIL reset_rsp_data got=%h exp=0", rsp_data);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
   endtask

   // Run a list of commands and compare data, latency and flags
   task automatic run_list(input string name, input logic ld[],
                           input logic [2:0] op[], input logic [3:0] b[],
                           input logic [2:0] cnt[]);
      int lat, elat;
      logic [3:0] d;
      logic [2:0] fl;
      for (int i = 0; i < ld.size(); i++) begin
         do_cmd(ld[i], op[i], b[i], cnt[i], lat, d, fl);
         model_cmd(ld[i], op[i], b[i], cnt[i], elat);
         checks++;
         if (d !== m_acc) begin
            failures++;
            $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, d, m_acc);
         end
         checks++;
         if (lat != elat) begin
            failures++;
            $display("FAIL %s_lat[%0d] got=%0d exp=%0d", name, i, lat, elat);
         end
`ifdef ALU_SEQUENCER_FLAGS_EN
         checks++;
         if (fl !== exp_flags()) begin
            failures++;
            $display("FAIL %s_flags[%0d] got=%b exp=%b", name, i, fl, exp_flags());
         end
`endif
      end
   endtask

   task automatic test_add_sub();
      run_list("addsub",
               '{1'b1, 1'b0, 1'b1, 1'b0},
               '{3'd0, 3'd0, 3'd0, 3'd1},
               '{4'd3, 4'd5, 4'd3, 4'd5},
               '{3'd0, 3'd0, 3'd0, 3'd0});
      checks++;
      if (m_acc !== 4'hE || rsp_data !== 4'hE) begin
         failures++;
         $display("FAIL sub_wrap_value got=%h exp=e", rsp_data);
      end
   endtask

   task automatic test_multi();
      run_list("multi",
               '{1'b1, 1'b0, 1'b0},
               '{3'd0, 3'd0, 3'd0},
               '{4'd3, 4'd3, 4'd1},
               '{3'd0, 3'd3, 3'd0});
      checks++;
      if (rsp_data !== 4'd0) begin
         failures++;
         $display("FAIL multi_final got=%h exp=0", rsp_data);
      end
   endtask

   task automatic test_opcodes();
      logic [3:0] want [6];
      int lat, elat;
      logic [3:0] d;
      logic [2:0] fl;
      want = '{4'd1, 4'd7, 4'd6, 4'd12, 4'd1, 4'd3};
      for (int k = 0; k < 6; k++) begin
         do_cmd(1'b1, 3'd0, 4'd3, 3'd0, lat, d, fl);
         model_cmd(1'b1, 3'd0, 4'd3, 3'd0, elat);
         do_cmd(1'b0, 3'(k + 2), 4'd5, 3'd0, lat, d, fl);
         model_cmd(1'b0, 3'(k + 2), 4'd5, 3'd0, elat);
         checks++;
         if (d !== want[k] || d !== m_acc) begin
            failures++;
            $display("FAIL opcode_%0d got=%h exp=%h", k + 2, d, want[k]);
         end
      end
   endtask

   task automatic test_random();
      int lat, elat;
      logic [3:0] d;
      logic [2:0] fl;
      logic ld;
      logic [2:0] op, cnt;
      logic [3:0] b;
      for (int i = 0; i < 40; i++) begin
         ld  = ($urandom_range(0, 5) == 0);
         op  = 3'($urandom);
         b   = 4'($urandom);
         cnt = 3'($urandom);
         do_cmd(ld, op, b, cnt, lat, d, fl);
         model_cmd(ld, op, b, cnt, elat);
         checks++;
         if (d !== m_acc || lat != elat) begin
            failures++;
            $display("FAIL rand[%0d] op=%0d data got=%h exp=%h lat got=%0d exp=%0d",
                     i, op, d, m_acc, lat, elat);
         end
`ifdef ALU_SEQUENCER_FLAGS_EN
         checks++;
         if (fl !== exp_flags()) begin
            failures++;
            $display("FAIL rand_flags[%0d] got=%b exp=%b", i, fl, exp_flags());
         end
`endif
      end
   endtask

   task automatic test_backpressure();
      int lat, elat;
      logic [3:0] d0, d;
      logic [2:0] fl;
      bit bad;
      rsp_ready = 1'b0;
      issue(1'b0, 3'd0, 4'd2, 3'd1);
      model_cmd(1'b0, 3'd0, 4'd2, 3'd1, elat);
      wait_rsp(lat);
      d0 = rsp_data;
      checks++;
      if (d0 !== m_acc) begin
         failures++;
         $display("FAIL bp_data got=%h exp=%h", d0, m_acc);
      end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data !== d0 || cmd_ready) bad = 1'b1;
         if (i == 2) begin
            cmd_load  = 1'b1;
            cmd_b     = ~m_acc;
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL bp_hold rsp_valid=%b data=%h cmd_ready=%b exp 1/%h/0",
                  rsp_valid, rsp_data, cmd_ready, d0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release rsp_valid got=%b exp=0", rsp_valid);
      end
      do_cmd(1'b0, 3'd7, 4'd0, 3'd0, lat, d, fl);
      model_cmd(1'b0, 3'd7, 4'd0, 3'd0, elat);
      checks++;
      if (d !== m_acc) begin
         failures++;
         $display("FAIL bp_acc_unchanged got=%h exp=%h", d, m_acc);
      end
   endtask

   task automatic test_back_to_back();
      int elat;
      logic [3:0] e1;
      bit bad;
      rsp_ready = 1'b1;
      @(negedge clk);
      cmd_load  = 1'b0;
      cmd_op    = 3'd0;
      cmd_b     = 4'd4;
      cmd_count = 3'd1;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      model_cmd(1'b0, 3'd0, 4'd4, 3'd1, elat);
      e1 = m_acc;
      cmd_op    = 3'd1;
      cmd_b     = 4'd3;
      cmd_count = 3'd0;
      bad = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (cmd_ready || rsp_valid) bad = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL b2b_exec_ready cmd_ready=%b exp=0", cmd_ready);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e1 || cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_first valid=%b data=%h ready=%b exp 1/%h/0",
                  rsp_valid, rsp_data, cmd_ready, e1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_idle valid=%b ready=%b exp 0/1", rsp_valid, cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      model_cmd(1'b0, 3'd1, 4'd3, 3'd0, elat);
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second_accept busy=%b valid=%b exp 1/0", busy, rsp_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== m_acc) begin
         failures++;
         $display("FAIL b2b_second valid=%b data=%h exp 1/%h", rsp_valid, rsp_data, m_acc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int lat, elat;
      logic [3:0] d;
      logic [2:0] fl;
      rsp_ready = 1'b1;
      issue(1'b0, 3'd0, 4'd1, 3'd7);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 4'd0) begin
         failures++;
         $display("FAIL midrst_state valid=%b busy=%b data=%h exp 0/0/0",
                  rsp_valid, busy, rsp_data);
      end
      @(negedge clk);
      rst    = 1'b0;
      m_acc  = 4'd0;
      m_wrap = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_ready got=%b exp=1", cmd_ready);
      end
      do_cmd(1'b1, 3'd0, 4'd0, 3'd0, lat, d, fl);
      model_cmd(1'b1, 3'd0, 4'd0, 3'd0, elat);
      do_cmd(1'b0, 3'd0, 4'd1, 3'd0, lat, d, fl);
      model_cmd(1'b0, 3'd0, 4'd1, 3'd0, elat);
      checks++;
      if (d !== 4'd1 || d !== m_acc) begin
         failures++;
         $display("FAIL midrst_add got=%h exp=1", d);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_add_sub();
      test_multi();
      test_opcodes();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
